enigma_core_seq: RTL and testbench

//  Clocked, parametrised successor to the combinational rotor stack: an N-rotor Enigma cipher core.
//  - One letter per transaction, over a valid/ready handshake.
//  - Each rotor is a run-time-selectable wheel with its own ring setting and position.
//  - Stepping includes the double-step anomaly. Reflector B or C is selected at run time.
//  - The path is iterated one rotor per cycle through one shared substitution unit.
//  - Sits between the keyboard/letter encoder and the lampboard/display driver.

---
 rtl/enigma_pkg.sv | 111 +++++++++++
 rtl/enigma_subst.sv | 22 ++
 rtl/enigma_core_seq.sv | 175 +++++++++++++++++
 tb/tb_enigma_core_seq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared types, wiring tables, notch letters and mod-26 helpers for the Enigma cipher core.
package enigma_pkg;

    localparam int unsigned LETTERS    = 26;
    localparam int unsigned LAST       = LETTERS - 1;
    localparam int unsigned LETTER_W   = 5;
    localparam int unsigned WHEEL_W    = 3;
    localparam int unsigned TBL_W      = 8 * LETTERS;
    localparam int unsigned STATE_W    = 3;

    typedef logic [LETTER_W-1:0] letter_t;
    typedef logic [WHEEL_W-1:0]  wheel_t;
    typedef logic [TBL_W-1:0]    tbl_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_STEP = 3'd1,
        ST_FWD  = 3'd2,
        ST_REFL = 3'd3,
        ST_BWD  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Tables are ASCII strings; entry i is the character at position i (leftmost = A).
    localparam tbl_t WHEEL_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam tbl_t WHEEL_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam tbl_t WHEEL_III = "BDFHJLCPRTXVZNYEIWGAKMSUQO";
    localparam tbl_t WHEEL_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
    localparam tbl_t WHEEL_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";
    localparam tbl_t REFL_B    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    localparam tbl_t REFL_C    = "FVPJIAOYEDRZXWGCTKUQSBNMHL";

    localparam letter_t NOTCH_I   = 5'd16;
    localparam letter_t NOTCH_II  = 5'd4;
    localparam letter_t NOTCH_III = 5'd21;
    localparam letter_t NOTCH_IV  = 5'd9;
    localparam letter_t NOTCH_V   = 5'd25;

    function automatic tbl_t invert_tbl(input tbl_t t);
        tbl_t r;
        int   c;
        r = '0;
        for (int i = 0; i < int'(LETTERS); i++) begin
            c = int'(t[8*(int'(LAST) - i) +: 8]) - 65;
            r[8*(int'(LAST) - c) +: 8] = 8'(65 + i);
        end
        return r;
    endfunction

    localparam tbl_t WHEEL_I_INV   = invert_tbl(WHEEL_I);
    localparam tbl_t WHEEL_II_INV  = invert_tbl(WHEEL_II);
    localparam tbl_t WHEEL_III_INV = invert_tbl(WHEEL_III);
    localparam tbl_t WHEEL_IV_INV  = invert_tbl(WHEEL_IV);
    localparam tbl_t WHEEL_V_INV   = invert_tbl(WHEEL_V);

    function automatic letter_t tbl_get(input tbl_t t, input letter_t i);
        logic [7:0] ch;
        ch = t[8*(int'(LAST) - int'(i)) +: 8];
        return LETTER_W'(ch - 8'd65);
    endfunction

    function automatic letter_t add26(input letter_t a, input letter_t b);
        logic [5:0] t;
        t = 6'(a) + 6'(b);
        if (t >= 6'(LETTERS)) t = t - 6'(LETTERS);
        return LETTER_W'(t);
    endfunction

    function automatic letter_t sub26(input letter_t a, input letter_t b);
        logic [5:0] t;
        t = 6'(a) + 6'(LETTERS) - 6'(b);
        if (t >= 6'(LETTERS)) t = t - 6'(LETTERS);
        return LETTER_W'(t);
    endfunction

    // Wheel ids 5..7 fall through to wheel I.
    function automatic letter_t wheel_fwd(input wheel_t w, input letter_t c);
        case (w)
            3'd1:    return tbl_get(WHEEL_II, c);
            3'd2:    return tbl_get(WHEEL_III, c);
            3'd3:    return tbl_get(WHEEL_IV, c);
            3'd4:    return tbl_get(WHEEL_V, c);
            default: return tbl_get(WHEEL_I, c);
        endcase
    endfunction

    function automatic letter_t wheel_inv(input wheel_t w, input letter_t c);
        case (w)
            3'd1:    return tbl_get(WHEEL_II_INV, c);
            3'd2:    return tbl_get(WHEEL_III_INV, c);
            3'd3:    return tbl_get(WHEEL_IV_INV, c);
            3'd4:    return tbl_get(WHEEL_V_INV, c);
            default: return tbl_get(WHEEL_I_INV, c);
        endcase
    endfunction

    function automatic letter_t wheel_notch(input wheel_t w);
        case (w)
            3'd1:    return NOTCH_II;
            3'd2:    return NOTCH_III;
            3'd3:    return NOTCH_IV;
            3'd4:    return NOTCH_V;
            default: return NOTCH_I;
        endcase
    endfunction

    function automatic letter_t reflect(input logic sel, input letter_t c);
        return sel ? tbl_get(REFL_C, c) : tbl_get(REFL_B, c);
    endfunction

endpackage

// File: rtl/enigma_subst.sv
// Single rotor substitution: shifts into the wheel frame, looks up forward or inverse wiring, shifts back.
module enigma_subst
    import enigma_pkg::*;
(
    input  logic [4:0] sig,
    input  logic [4:0] pos,
    input  logic [4:0] ring,
    input  logic [2:0] wheel,
    input  logic       dir,
    output logic [4:0] result_c
);

    letter_t entry_c;
    letter_t wired_c;

    always_comb begin
        entry_c  = sub26(add26(sig, pos), ring);
        wired_c  = dir ? wheel_inv(wheel, entry_c) : wheel_fwd(wheel, entry_c);
        result_c = add26(sub26(wired_c, pos), ring);
    end

endmodule

// File: rtl/enigma_core_seq.sv
// N-rotor Enigma core, one rotor substitution per cycle through a shared enigma_subst.
// Optional plugboard enabled by defining PLUGBOARD_EN.
module enigma_core_seq
    import enigma_pkg::*;
#(
    parameter int unsigned NUM_ROTORS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_letter,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_letter,
    output logic                    err,
    output logic                    busy,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_sel,
    input  logic [2:0]              cfg_wheel,
    input  logic [4:0]              cfg_ring,
    input  logic [4:0]              cfg_pos,
    input  logic                    refl_sel,
`ifdef PLUGBOARD_EN
    input  logic                    plug_we,
    input  logic [4:0]              plug_a,
    input  logic [4:0]              plug_b,
`endif
    output logic [5*NUM_ROTORS-1:0] pos_flat
);

    localparam int unsigned IDX_W = $clog2(NUM_ROTORS);

    state_t           state_q;
    logic [IDX_W-1:0] k_q;
    letter_t          sig_q;
    logic             refl_q;
    letter_t          pos_q   [NUM_ROTORS];
    letter_t          ring_q  [NUM_ROTORS];
    wheel_t           wheel_q [NUM_ROTORS];

    logic [NUM_ROTORS-1:0] at_notch_c;
    logic [NUM_ROTORS-1:0] step_c;
    letter_t               subst_c;
    letter_t               plug_sig_c;

    for (genvar g = 0; g < int'(NUM_ROTORS); g++) begin : g_slot
        assign pos_flat[5*g +: 5] = pos_q[g];
        assign at_notch_c[g]      = (pos_q[g] == wheel_notch(wheel_q[g]));
    end

    // Step decision on pre-step positions; slot 1 also steps on its own notch (double step).
    always_comb begin
        step_c    = '0;
        step_c[0] = 1'b1;
        step_c[1] = at_notch_c[0] | at_notch_c[1];
        step_c[2] = at_notch_c[1];
    end

    enigma_subst u_subst (
        .sig      (sig_q),
        .pos      (pos_q[k_q]),
        .ring     (ring_q[k_q]),
        .wheel    (wheel_q[k_q]),
        .dir      (state_q == ST_BWD),
        .result_c (subst_c)
    );

`ifdef PLUGBOARD_EN
    letter_t plug_q [LETTERS];

    // Swap table entries on a legal write while idle; a == b or out-of-range letters are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LETTERS); i++) plug_q[i] <= LETTER_W'(i);
        end else if (state_q == ST_IDLE && plug_we && plug_a != plug_b &&
                     plug_a < LETTER_W'(LETTERS) && plug_b < LETTER_W'(LETTERS)) begin
            plug_q[plug_a] <= plug_q[plug_b];
            plug_q[plug_b] <= plug_q[plug_a];
        end
    end

    assign plug_sig_c = plug_q[sig_q];
`else
    assign plug_sig_c = sig_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            sig_q      <= '0;
            refl_q     <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_letter <= '0;
            err        <= 1'b0;
            for (int i = 0; i < int'(NUM_ROTORS); i++) begin
                pos_q[i]   <= '0;
                ring_q[i]  <= '0;
                wheel_q[i] <= WHEEL_W'(i);
            end
        end else begin
            err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // An accepted letter, legal or not, takes priority over a config write.
                    if (in_valid) begin
                        if (in_letter < LETTER_W'(LETTERS)) begin
                            sig_q    <= in_letter;
                            refl_q   <= refl_sel;
                            state_q  <= ST_STEP;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (cfg_we && 32'(cfg_sel) < NUM_ROTORS) begin
                        wheel_q[IDX_W'(cfg_sel)] <= cfg_wheel;
                        ring_q[IDX_W'(cfg_sel)]  <= cfg_ring;
                        pos_q[IDX_W'(cfg_sel)]   <= cfg_pos;
                    end
                end
                ST_STEP: begin
                    for (int i = 0; i < int'(NUM_ROTORS); i++) begin
                        if (step_c[i]) pos_q[i] <= add26(pos_q[i], 5'd1);
                    end
                    sig_q   <= plug_sig_c;
                    k_q     <= '0;
                    state_q <= ST_FWD;
                end
                ST_FWD: begin
                    sig_q <= subst_c;
                    if (k_q == IDX_W'(NUM_ROTORS - 1)) begin
                        state_q <= ST_REFL;
                    end else begin
                        k_q <= k_q + IDX_W'(1);
                    end
                end
                ST_REFL: begin
                    sig_q   <= reflect(refl_q, sig_q);
                    k_q     <= IDX_W'(NUM_ROTORS - 1);
                    state_q <= ST_BWD;
                end
                ST_BWD: begin
                    sig_q <= subst_c;
                    if (k_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // First DONE cycle presents the letter; then hold until downstream takes it.
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_letter <= plug_sig_c;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_core_seq.sv
// Self-checking bench for enigma_core_seq against a string-table Enigma model (PLUGBOARD_EN optional).
module tb_enigma_core_seq;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4:0]     in_letter = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [4:0]     out_letter;
    logic           err;
    logic           busy;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_sel = '0;
    logic [2:0]     cfg_wheel = '0;
    logic [4:0]     cfg_ring = '0;
    logic [4:0]     cfg_pos = '0;
    logic           refl_sel = 1'b0;
    logic [5*N-1:0] pos_flat;
`ifdef PLUGBOARD_EN
    logic           plug_we = 1'b0;
    logic [4:0]     plug_a = '0;
    logic [4:0]     plug_b = '0;
`endif

    int checks = 0;
    int errors = 0;

    enigma_core_seq #(.NUM_ROTORS(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_letter  (in_letter),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_letter (out_letter),
        .err        (err),
        .busy       (busy),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_wheel  (cfg_wheel),
        .cfg_ring   (cfg_ring),
        .cfg_pos    (cfg_pos),
        .refl_sel   (refl_sel),
`ifdef PLUGBOARD_EN
        .plug_we    (plug_we),
        .plug_a     (plug_a),
        .plug_b     (plug_b),
`endif
        .pos_flat   (pos_flat)
    );

    always #5 clk = ~clk;

    // Reference machine: wiring as letter strings, plain modular arithmetic.
    string WSTR[5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEIWGAKMSUQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                       "VZBRGITYUPSDNHLXAWMJQOFECK"};
    string RSTR[2] = '{"YRUHQSLDPXNGOKMIEBFZCWVJAT", "FVPJIAOYEDRZXWGCTKUQSBNMHL"};
    int    NOTCH[5] = '{16, 4, 21, 9, 25};
    int    m_pos[4];
    int    m_ring[4];
    int    m_wheel[4];
    int    m_plug[26];

    function automatic int mod26(input int v);
        return ((v % 26) + 26) % 26;
    endfunction

    function automatic int wid(input int w);
        return (w > 4) ? 0 : w;
    endfunction

    function automatic int wire_letter(input int w, input int x);
        return int'(WSTR[wid(w)].getc(x)) - 65;
    endfunction

    function automatic int rotor_fwd(input int k, input int s);
        int sh;
        sh = m_pos[k] - m_ring[k];
        return mod26(wire_letter(m_wheel[k], mod26(s + sh)) - sh);
    endfunction

    function automatic int rotor_bwd(input int k, input int s);
        int sh, x, y;
        sh = m_pos[k] - m_ring[k];
        x  = mod26(s + sh);
        y  = 0;
        for (int i = 0; i < 26; i++) if (wire_letter(m_wheel[k], i) == x) y = i;
        return mod26(y - sh);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_pos[k] = 0; m_ring[k] = 0; m_wheel[k] = k;
        end
        for (int i = 0; i < 26; i++) m_plug[i] = i;
    endtask

    task automatic model_encrypt(input int c, input int refl, output int r);
        bit at0, at1;
        int s;
        at0 = (m_pos[0] == NOTCH[wid(m_wheel[0])]);
        at1 = (m_pos[1] == NOTCH[wid(m_wheel[1])]);
        m_pos[0] = mod26(m_pos[0] + 1);
        if (at0 || at1) m_pos[1] = mod26(m_pos[1] + 1);
        if (at1 && N > 2) m_pos[2] = mod26(m_pos[2] + 1);
        s = m_plug[c];
        for (int k = 0; k < N; k++) s = rotor_fwd(k, s);
        s = int'(RSTR[refl].getc(s)) - 65;
        for (int k = N - 1; k >= 0; k--) s = rotor_bwd(k, s);
        r = m_plug[s];
    endtask

    function automatic logic [5*N-1:0] model_pos_flat();
        logic [5*N-1:0] v;
        for (int k = 0; k < N; k++) v[5*k +: 5] = 5'(m_pos[k]);
        return v;
    endfunction

    task automatic cfg_write(input int sel, input int w, input int r, input int p);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_wheel = 3'(w); cfg_ring = 5'(r); cfg_pos = 5'(p);
        @(negedge clk);
        cfg_we = 1'b0;
        if (sel < N) begin
            m_wheel[sel] = w; m_ring[sel] = r; m_pos[sel] = p;
        end
    endtask

    task automatic setup_classic();
        cfg_write(0, 2, 0, 0);
        cfg_write(1, 1, 0, 0);
        cfg_write(2, 0, 0, 0);
    endtask

    // One transaction: accept, measure latency, optional backpressure with an ignored cfg write, release.
    task automatic send(input int letter, input int refl, input int hold, input bit clash, input int exp);
        int lat;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_letter = 5'(letter); refl_sel = refl[0];
        if (clash) begin
            cfg_we = 1'b1; cfg_sel = 2'd0; cfg_wheel = 3'd4; cfg_ring = 5'd5; cfg_pos = 5'd9;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != 2*N + 3) begin
            errors++; $display("FAIL latency: got %0d cycles required %0d", lat, 2*N + 3);
        end
        if (out_valid !== 1'b1) return;
        checks++;
        if (out_letter !== 5'(exp)) begin
            errors++; $display("FAIL cipher: letter %0d got %0d required %0d", letter, out_letter, exp);
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                cfg_we = 1'b1; cfg_sel = 2'd0; cfg_wheel = 3'd3; cfg_ring = 5'd7; cfg_pos = 5'd13;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_letter !== 5'(exp) || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold: cycle %0d valid=%b letter=%0d ready=%b busy=%b required 1/%0d/0/1",
                         i, out_valid, out_letter, in_ready, busy, exp);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: valid=%b ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
        end
        checks++;
        if (pos_flat !== model_pos_flat()) begin
            errors++; $display("FAIL pos_flat: got %h required %h", pos_flat, model_pos_flat());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ready: ready=%b busy=%b required 1/0", in_ready, busy);
        end
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || out_letter !== 5'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b err=%b letter=%0d required 0/0/0", out_valid, err, out_letter);
        end
        checks++;
        if (pos_flat !== '0) begin
            errors++; $display("FAIL reset_pos: got %h required 0", pos_flat);
        end
        @(negedge clk); reset = 1'b0;
        model_reset();
    endtask

    task automatic test_known_vector();
        int expv[5] = '{1, 3, 25, 6, 14};
        int m;
        setup_classic();
        for (int i = 0; i < 5; i++) begin
            model_encrypt(0, 0, m);
            send(0, 0, 0, 1'b0, expv[i]);
        end
    endtask

    task automatic test_double_step();
        logic [5*N-1:0] exp_pf[3];
        int m;
        exp_pf[0] = {5'd0, 5'd3, 5'd21};
        exp_pf[1] = {5'd0, 5'd4, 5'd22};
        exp_pf[2] = {5'd1, 5'd5, 5'd23};
        setup_classic();
        cfg_write(0, 2, 0, 20);
        cfg_write(1, 1, 0, 3);
        for (int i = 0; i < 3; i++) begin
            model_encrypt(0, 0, m);
            send(0, 0, 0, 1'b0, m);
            checks++;
            if (pos_flat !== exp_pf[i]) begin
                errors++; $display("FAIL double_step: step %0d got %h required %h", i, pos_flat, exp_pf[i]);
            end
        end
    endtask

    task automatic test_reciprocity();
        int inv[5] = '{1, 3, 25, 6, 14};
        int m;
        setup_classic();
        for (int i = 0; i < 5; i++) begin
            model_encrypt(inv[i], 0, m);
            send(inv[i], 0, 0, 1'b0, 0);
        end
    endtask

    task automatic test_illegal();
        int bad[3] = '{26, 27, 31};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_letter = 5'(bad[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse: letter %0d err=%b ready=%b busy=%b required 1/1/0",
                         bad[i], err, in_ready, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b0 || out_valid !== 1'b0 || pos_flat !== model_pos_flat()) begin
                errors++;
                $display("FAIL illegal_after: err=%b valid=%b pos=%h required 0/0/%h",
                         err, out_valid, pos_flat, model_pos_flat());
            end
        end
    endtask

    task automatic test_backpressure();
        int m;
        model_encrypt(7, 1, m);
        send(7, 1, 20, 1'b0, m);
    endtask

    task automatic test_cfg_priority();
        int m;
        model_encrypt(4, 0, m);
        send(4, 0, 0, 1'b1, m);
        cfg_write(3, 4, 9, 9);
        @(posedge clk); #1;
        checks++;
        if (pos_flat !== model_pos_flat()) begin
            errors++; $display("FAIL cfg_sel_range: got %h required %h", pos_flat, model_pos_flat());
        end
    endtask

    task automatic test_random();
        int m, c, r;
        for (int t = 0; t < 40; t++) begin
            if (t % 8 == 0) begin
                for (int k = 0; k < N; k++)
                    cfg_write(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 25)),
                              int'($urandom_range(0, 25)));
            end
            c = int'($urandom_range(0, 25));
            r = int'($urandom_range(0, 1));
            model_encrypt(c, r, m);
            send(c, r, int'($urandom_range(0, 2)), 1'b0, m);
        end
    endtask

    task automatic test_reset_midflight();
        int m;
        cfg_write(0, 4, 3, 11);
        @(negedge clk);
        in_valid = 1'b1; in_letter = 5'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || pos_flat !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b ready=%b valid=%b pos=%h required 0/1/0/0",
                     busy, in_ready, out_valid, pos_flat);
        end
        @(negedge clk); reset = 1'b0;
        model_reset();
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_out: out_valid=%b required 0", out_valid);
        end
        model_encrypt(0, 0, m);
        send(0, 0, 0, 1'b0, m);
    endtask

`ifdef PLUGBOARD_EN
    task automatic plug_write(input int a, input int b);
        int t;
        @(negedge clk);
        plug_we = 1'b1; plug_a = 5'(a); plug_b = 5'(b);
        @(negedge clk);
        plug_we = 1'b0;
        if (a != b && a < 26 && b < 26) begin
            t = m_plug[a]; m_plug[a] = m_plug[b]; m_plug[b] = t;
        end
    endtask

    task automatic test_plugboard();
        int m;
        setup_classic();
        plug_write(0, 25);
        plug_write(3, 3);
        plug_write(2, 28);
        model_encrypt(0, 0, m);
        send(0, 0, 0, 1'b0, m);
        checks++;
        if (out_letter === 5'd1) begin
            errors++; $display("FAIL plug_effect: got %0d required not 1", out_letter);
        end
        for (int i = 0; i < 4; i++) begin
            model_encrypt(i * 5, i % 2, m);
            send(i * 5, i % 2, 0, 1'b0, m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_double_step();
        test_reciprocity();
        test_illegal();
        test_backpressure();
        test_cfg_priority();
        test_random();
        test_reset_midflight();
`ifdef PLUGBOARD_EN
        test_plugboard();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
